// File: rtl/pg_fifo_scheduler_if.sv
// Scheduler-side handshake bundle: register-file controls, shared FIFO read port, SPI read path, pattern output.
// With PG_LOOP_EN defined the bundle also carries the FIFO write-back port.
interface pg_fifo_scheduler_if #(
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          start_pg;
    logic [CW-1:0] pg_speed;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd_en;
    logic          spi_rd_req;
    logic          spi_rd_ack;
    logic [DW-1:0] spi_rd_data;
    logic [DW-1:0] pg_out;
    logic          pg_valid;
    logic          pg_busy;
    logic          pg_done;
    logic          pg_abort;
`ifdef PG_LOOP_EN
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wdata;

    modport master (
        output start_pg, pg_speed, fifo_empty, fifo_rdata, spi_rd_req,
        input  fifo_rd_en, spi_rd_ack, spi_rd_data, pg_out, pg_valid,
               pg_busy, pg_done, pg_abort, fifo_wr_en, fifo_wdata
    );
    modport slave (
        input  start_pg, pg_speed, fifo_empty, fifo_rdata, spi_rd_req,
        output fifo_rd_en, spi_rd_ack, spi_rd_data, pg_out, pg_valid,
               pg_busy, pg_done, pg_abort, fifo_wr_en, fifo_wdata
    );
`else
    modport master (
        output start_pg, pg_speed, fifo_empty, fifo_rdata, spi_rd_req,
        input  fifo_rd_en, spi_rd_ack, spi_rd_data, pg_out, pg_valid,
               pg_busy, pg_done, pg_abort
    );
    modport slave (
        input  start_pg, pg_speed, fifo_empty, fifo_rdata, spi_rd_req,
        output fifo_rd_en, spi_rd_ack, spi_rd_data, pg_out, pg_valid,
               pg_busy, pg_done, pg_abort
    );
`endif
endinterface

// File: rtl/pg_fifo_scheduler.sv
// Pattern-generator sequencer: pops FIFO words and holds each on pg_out for max(pg_speed,2) cycles; shares the FIFO read port with SPI reads.
// Latency: first word 2 cycles after the start edge; SPI ack 2 cycles after the request when the PG is not popping.
// Backpressure: none downstream; the PG wins read-port conflicts and SPI waits one cycle. PG_LOOP_EN adds FIFO write-back looping.
module pg_fifo_scheduler #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic clk,
    input  logic reset,
    pg_fifo_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state, state_nxt;
    logic          start_q, start_edge;
    logic          next_ok;
    logic          spi_pend, spi_ack_q, spi_hit_q;
    logic          pg_pop, spi_serve, spi_pop;
    logic          load_word, abort, done_set;
    logic          at_pop, at_last;
    logic [CW-1:0] cnt, n_q;

`ifdef PG_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
    assign bus.fifo_wr_en = load_word & ~reset;
    assign bus.fifo_wdata = bus.fifo_rdata;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    assign start_edge = bus.start_pg & ~start_q;
    assign at_pop     = (cnt == n_q - CW'(2));
    assign at_last    = (cnt == n_q - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pg_pop    = 1'b0;
        load_word = 1'b0;
        abort     = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    if (!bus.fifo_empty) begin
                        pg_pop    = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        done_set  = !LOOP_EN;
                    end
                end
            end
            LOAD: begin
                if (!bus.start_pg) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    load_word = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.start_pg) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (at_last) begin
                    if (next_ok) begin
                        load_word = 1'b1;
                    end else begin
                        done_set  = !LOOP_EN;
                        state_nxt = IDLE;
                    end
                end else if (at_pop) begin
                    pg_pop = !bus.fifo_empty;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SPI only gets the read port in cycles the PG leaves free
    assign spi_serve      = spi_pend & ~pg_pop;
    assign spi_pop        = spi_serve & ~bus.fifo_empty;
    assign bus.fifo_rd_en = (pg_pop | spi_pop) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q      <= 1'b0;
            cnt          <= '0;
            n_q          <= CW'(2);
            next_ok      <= 1'b0;
            spi_pend     <= 1'b0;
            spi_ack_q    <= 1'b0;
            spi_hit_q    <= 1'b0;
            bus.pg_out   <= '0;
            bus.pg_valid <= 1'b0;
            bus.pg_done  <= 1'b0;
            bus.pg_abort <= 1'b0;
        end else begin
            start_q <= bus.start_pg;
            if (state == IDLE && start_edge)
                n_q <= (bus.pg_speed < CW'(2)) ? CW'(2) : bus.pg_speed;
            if (load_word) begin
                bus.pg_out   <= bus.fifo_rdata;
                bus.pg_valid <= 1'b1;
                cnt          <= '0;
            end else begin
                if (state == RUN)      cnt          <= cnt + CW'(1);
                if (state_nxt == IDLE) bus.pg_valid <= 1'b0;
            end
            if (state == RUN && at_pop) next_ok <= pg_pop;
            bus.pg_done  <= done_set;
            bus.pg_abort <= abort;
            spi_pend     <= spi_serve ? 1'b0 : (spi_pend | bus.spi_rd_req);
            spi_ack_q    <= spi_serve;
            spi_hit_q    <= spi_pop;
        end
    end

    assign bus.spi_rd_ack  = spi_ack_q;
    assign bus.spi_rd_data = spi_hit_q ? bus.fifo_rdata : {DW{1'b0}};
    assign bus.pg_busy     = (state != IDLE);
endmodule

// File: tb/tb_pg_fifo_scheduler.sv
// Bench for pg_fifo_scheduler: behavioural FIFO plus a per-cycle schedule model of the pattern output and SPI reads.
module tb_pg_fifo_scheduler;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    pg_fifo_scheduler_if #(.DW(DW), .CW(CW)) bus();
    pg_fifo_scheduler #(.DW(DW), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural FIFO: registered read data, empty flag updated at the clock edge
    logic [DW-1:0] fq[$];
    logic [DW-1:0] left_q[$];
    logic          push_en;
    logic [DW-1:0] push_dat;
    int            pops = 0, consec = 0, underflow = 0;
    bit            last_pop = 1'b0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            pops <= pops + 1;
            if (last_pop) consec <= consec + 1;
            if (fq.size() == 0) underflow <= underflow + 1;
            else bus.fifo_rdata <= fq.pop_front();
        end
        last_pop <= bus.fifo_rd_en;
        if (push_en) fq.push_back(push_dat);
        bus.fifo_empty <= (fq.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        push_en  = 1'b1;
        push_dat = w;
        tick();
        push_en  = 1'b0;
    endtask

    task automatic spi_read(input logic [DW-1:0] exp_d, input int exp_pop);
        int p0, lat;
        p0 = pops;
        lat = -1;
        bus.spi_rd_req = 1'b1;
        tick();
        bus.spi_rd_req = 1'b0;
        for (int i = 0; i < 6 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.spi_rd_ack) begin
                lat = i;
                chk("spi_data", bus.spi_rd_data, exp_d);
            end
            tick();
        end
        chk("spi_ack_latency", lat, 1);
        chk("spi_pops", pops - p0, exp_pop);
    endtask

    task automatic drain();
        while (left_q.size() > 0) spi_read(left_q.pop_front(), 1);
        spi_read('0, 0);
    endtask

    // abort_at: cycle (relative to the start edge) in which start_pg is seen low; -1 = run to completion
    task automatic run_pg(input int nw, input int spd, input int abort_at);
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        int n, endc, stop, p0, c0, npop;
        bit ev, eb;
        n = (spd < 2) ? 2 : spd;
        for (int i = 0; i < nw; i++) begin
            w = DW'($urandom);
            words.push_back(w);
            push_word(w);
        end
        p0 = pops;
        c0 = consec;
        endc = (nw == 0) ? 1 : 2 + nw * n;
        stop = (abort_at >= 0) ? abort_at + 1 : endc;
        bus.pg_speed = CW'(spd);
        bus.start_pg = 1'b1;
        for (int c = 0; c <= stop + 2; c++) begin
            @(negedge clk);
            ev = (nw > 0) && c >= 2 && c < stop;
            eb = (nw > 0) && c >= 1 && c < stop;
            chk("pg_valid", bus.pg_valid, ev);
            chk("pg_busy", bus.pg_busy, eb);
            chk("pg_done", bus.pg_done, (abort_at < 0) && c == endc);
            chk("pg_abort", bus.pg_abort, (abort_at >= 0) && c == stop);
            if (ev) chk("pg_out", bus.pg_out, words[(c - 2) / n]);
            if (abort_at < 0 && nw > 0 && c == endc) chk("pg_hold", bus.pg_out, words[nw - 1]);
            tick();
            bus.pg_speed = CW'($urandom);
            if (abort_at >= 0 && c + 1 == abort_at) bus.start_pg = 1'b0;
        end
        if (abort_at < 0) begin
            npop = nw;
            // level held high after the run ended: new data must not start anything
            w = DW'($urandom);
            push_word(w);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("hold_no_restart", {bus.pg_valid, bus.pg_busy}, 2'b00);
                tick();
            end
        end else begin
            npop = 1;
            for (int k = 0; k <= nw - 2; k++) if (n + k * n < abort_at) npop++;
        end
        bus.start_pg = 1'b0;
        tick();
        chk("pg_pops", pops - p0, npop);
        chk("pg_consec_pops", consec - c0, 0);
        for (int i = npop; i < nw; i++) left_q.push_back(words[i]);
        if (abort_at < 0) left_q.push_back(w);
    endtask

    // SPI request lands in the cycle the PG pops its second word
    task automatic conflict_test(input int n);
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        int p0, endc;
        bit ev;
        for (int i = 0; i < 3; i++) begin
            w = DW'($urandom);
            words.push_back(w);
            push_word(w);
        end
        p0 = pops;
        endc = 2 + 2 * n;
        bus.pg_speed = CW'(n);
        bus.start_pg = 1'b1;
        for (int c = 0; c <= endc + 2; c++) begin
            @(negedge clk);
            ev = c >= 2 && c < endc;
            chk("cf_valid", bus.pg_valid, ev);
            if (ev) chk("cf_out", bus.pg_out, words[(c - 2) / n]);
            chk("cf_done", bus.pg_done, c == endc);
            chk("cf_ack", bus.spi_rd_ack, c == n + 2);
            if (c == n + 2) chk("cf_spi_data", bus.spi_rd_data, words[2]);
            tick();
            bus.spi_rd_req = (c + 1 == n);
        end
        bus.start_pg = 1'b0;
        tick();
        chk("cf_pops", pops - p0, 3);
        spi_read('0, 0);
    endtask

    task automatic reset_mid_run();
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        int p0;
        for (int i = 0; i < 4; i++) begin
            w = DW'($urandom);
            words.push_back(w);
            push_word(w);
        end
        p0 = pops;
        bus.pg_speed = CW'(5);
        bus.start_pg = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 11) begin
                chk("rst_pg_out", bus.pg_out, 0);
                chk("rst_flags", {bus.pg_valid, bus.pg_busy, bus.pg_done, bus.pg_abort, bus.spi_rd_ack}, 0);
            end
            tick();
            if (c + 1 == 9) bus.spi_rd_req = 1'b1;
            if (c + 1 == 10) begin
                bus.spi_rd_req = 1'b0;
                bus.start_pg   = 1'b0;
                reset          = 1'b1;
            end
            if (c + 1 == 11) reset = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_spi_dropped", bus.spi_rd_ack, 0);
            tick();
        end
        chk("rst_pops", pops - p0, 2);
        left_q.push_back(words[2]);
        left_q.push_back(words[3]);
    endtask

    initial begin
        int nw, spd, n, ab;
        reset          = 1'b1;
        push_en        = 1'b0;
        push_dat       = '0;
        bus.start_pg   = 1'b0;
        bus.pg_speed   = '0;
        bus.spi_rd_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_pg_out", bus.pg_out, 0);
        chk("reset_flags", {bus.pg_valid, bus.pg_busy, bus.pg_done, bus.pg_abort}, 0);
        chk("reset_spi", {bus.spi_rd_ack, bus.spi_rd_data}, 0);
        chk("reset_rd_en", bus.fifo_rd_en, 0);
        tick();

        run_pg(4, 10, -1); drain();
        run_pg(2, 0, -1);  drain();
        run_pg(2, 1, -1);  drain();
        run_pg(3, 5, 9);   drain();
        run_pg(3, 4, 1);   drain();
        run_pg(0, 4, -1);  drain();
        conflict_test(3);
        conflict_test(2);
        reset_mid_run();   drain();

        for (int r = 0; r < 12; r++) begin
            nw  = $urandom_range(0, 5);
            spd = $urandom_range(0, 7);
            n   = (spd < 2) ? 2 : spd;
            ab  = -1;
            if (nw > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, 1 + nw * n);
            run_pg(nw, spd, ab);
            drain();
        end

        chk("fifo_underflow", underflow, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
